// File: rtl/elliptic_curve_structs.sv
// Shared curve types and field constants for the point arithmetic blocks.
// The bench field is the 16-bit prime 65521; points are affine (x, y).
package elliptic_curve_structs;

  localparam int                 P_WIDTH = 16;
  localparam logic [P_WIDTH-1:0] PRIME   = 16'd65521;

  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
  } curve_point_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL0,
    WINV,
    MUL1,
    MUL2,
    MUL3,
    DONE
  } pd_state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_T0,
    SEL_S,
    SEL_Q,
    SEL_M
  } mul_sel_t;

endpackage

// File: rtl/ModMul.sv
// Bit-serial interleaved modular multiplier, MSB first, one bit per enabled cycle.
// Operands load while i_reset is high; o_done rises P_WIDTH+1 cycles after the reset cycle.
module ModMul
  import elliptic_curve_structs::*;
(
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [P_WIDTH-1:0] i_a,
  input  logic [P_WIDTH-1:0] i_b,
  output logic [P_WIDTH-1:0] o_result,
  output logic               o_done
);

  localparam int               CW      = $clog2(P_WIDTH + 1);
  localparam logic [P_WIDTH:0] PRIME_X = {1'b0, PRIME};

  logic [P_WIDTH-1:0] r_a;
  logic [P_WIDTH-1:0] r_b;
  logic [P_WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_done;

  logic [P_WIDTH:0]   w_dbl;
  logic [P_WIDTH:0]   w_dbl_red;
  logic [P_WIDTH:0]   w_sum;
  logic [P_WIDTH-1:0] w_addend;
  logic [P_WIDTH-1:0] w_acc_next;

  always_comb begin
    w_dbl      = {r_acc, 1'b0};
    w_dbl_red  = (w_dbl >= PRIME_X) ? (w_dbl - PRIME_X) : w_dbl;
    w_addend   = r_a[P_WIDTH-1] ? r_b : {P_WIDTH{1'b0}};
    w_sum      = w_dbl_red + {1'b0, w_addend};
    w_acc_next = (w_sum >= PRIME_X) ? P_WIDTH'(w_sum - PRIME_X) : w_sum[P_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_cnt  <= CW'(P_WIDTH);
      r_done <= 1'b0;
    end else if (i_enable && !r_done) begin
      r_acc <= w_acc_next;
      r_a   <= r_a << 1;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_done <= 1'b1;
    end
  end

  assign o_result = r_acc;
  assign o_done   = r_done;

endmodule

// File: rtl/add.sv
// Modular add/subtract with a fully reduced result in [0, p).
// Both operands must already be reduced below p.
module add
  import elliptic_curve_structs::*;
(
  input  logic [P_WIDTH-1:0] i_a,
  input  logic [P_WIDTH-1:0] i_b,
  input  logic               i_sub,
  output logic [P_WIDTH-1:0] o_y
);

  localparam logic [P_WIDTH:0] PRIME_X = {1'b0, PRIME};

  logic [P_WIDTH:0] w_raw;

  // Subtraction adds (p - b) so the raw value never goes negative.
  always_comb begin
    w_raw = i_sub ? ({1'b0, i_a} + (PRIME_X - {1'b0, i_b}))
                  : ({1'b0, i_a} + {1'b0, i_b});
    o_y   = (w_raw >= PRIME_X) ? P_WIDTH'(w_raw - PRIME_X) : w_raw[P_WIDTH-1:0];
  end

endmodule

// File: rtl/modular_inverse.sv
// Field inverse by Fermat exponentiation x^(p-2), right-to-left, sharing one product per cycle.
// Runs freely after reset release; o_done rises 2*P_WIDTH+1 cycles after the reset cycle.
module modular_inverse
  import elliptic_curve_structs::*;
(
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [2*P_WIDTH-1:0] i_x,
  output logic [P_WIDTH-1:0]   o_result,
  output logic                 o_done
);

  localparam int                   CW      = $clog2(P_WIDTH + 1);
  localparam logic [P_WIDTH-1:0]   EXP     = PRIME - P_WIDTH'(2);
  localparam logic [2*P_WIDTH-1:0] PRIME_W = {{P_WIDTH{1'b0}}, PRIME};

  logic [P_WIDTH-1:0] r_base;
  logic [P_WIDTH-1:0] r_res;
  logic [P_WIDTH-1:0] r_exp;
  logic [CW-1:0]      r_cnt;
  logic               r_phase;
  logic               r_done;

  logic [P_WIDTH-1:0] w_op;
  logic [P_WIDTH-1:0] w_prod;

  // Phase 0 folds the base into the result, phase 1 squares the base.
  always_comb begin
    w_op   = r_phase ? r_base : r_res;
    w_prod = P_WIDTH'(({{P_WIDTH{1'b0}}, w_op} * {{P_WIDTH{1'b0}}, r_base}) % PRIME_W);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_base  <= P_WIDTH'(i_x % PRIME_W);
      r_res   <= P_WIDTH'(1);
      r_exp   <= EXP;
      r_cnt   <= CW'(P_WIDTH);
      r_phase <= 1'b0;
      r_done  <= 1'b0;
    end else if (!r_done) begin
      if (!r_phase) begin
        if (r_exp[0]) r_res <= w_prod;
        r_phase <= 1'b1;
      end else begin
        r_base  <= w_prod;
        r_exp   <= r_exp >> 1;
        r_cnt   <= r_cnt - CW'(1);
        r_phase <= 1'b0;
        if (r_cnt == CW'(1)) r_done <= 1'b1;
      end
    end
  end

  assign o_result = r_res;
  assign o_done   = r_done;

endmodule

// File: rtl/point_double_ctrl_mul_issue.sv
// Issue sequencer for the shared ModMul: reset pulse on the first cycle of an op,
// enable held afterwards, and a one-cycle op-done when the multiplier finishes.
module mul_issue (
  input  logic clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_mul_done,
  output logic o_mul_reset,
  output logic o_mul_enable,
  output logic o_op_done
);

  logic r_active;

  assign o_mul_reset  = i_req & ~r_active;
  assign o_mul_enable = i_req & r_active;
  assign o_op_done    = i_req & r_active & i_mul_done;

  // Clearing on op-done makes the next MULn state start with a fresh reset pulse.
  always_ff @(posedge clk) begin
    if (i_rst)          r_active <= 1'b0;
    else if (o_op_done) r_active <= 1'b0;
    else                r_active <= i_req;
  end

endmodule

// File: rtl/point_double_ctrl.sv
// Affine point doubler R = 2P: IDLE latch | CHECK infinity/Py=0, launch inverse | MUL0 3Px^2+a
// | WINV wait inverse | MUL1 slope | MUL2 Rx | MUL3 Ry | DONE one-cycle result strobe.
module point_double_ctrl
  import elliptic_curve_structs::*;
#(
  parameter logic [P_WIDTH-1:0] CURVE_A = '0
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         start,
  input  curve_point_t P,
  input  logic         P_inf,
  output logic         busy,
  output logic         Done,
  output curve_point_t R,
  output logic         R_inf
);

  pd_state_t r_state;
  pd_state_t w_next;
  mul_sel_t  w_sel;

  logic [P_WIDTH-1:0] r_px;
  logic [P_WIDTH-1:0] r_py;
  logic [P_WIDTH-1:0] r_px2;
  logic [P_WIDTH-1:0] r_py2;
  logic [P_WIDTH-1:0] r_t0;
  logic [P_WIDTH-1:0] r_inv;
  logic [P_WIDTH-1:0] r_s;
  logic [P_WIDTH-1:0] r_rx;
  logic               r_pinf;
  curve_point_t       r_r;
  logic               r_r_inf;

  logic [P_WIDTH-1:0] w_px2;
  logic [P_WIDTH-1:0] w_py2;
  logic [P_WIDTH-1:0] w_px3;
  logic [P_WIDTH-1:0] w_t0;
  logic [P_WIDTH-1:0] w_rx;
  logic [P_WIDTH-1:0] w_px_rx;
  logic [P_WIDTH-1:0] w_ry;
  logic [P_WIDTH-1:0] w_mul_a;
  logic [P_WIDTH-1:0] w_mul_b;
  logic [P_WIDTH-1:0] w_mul_res;
  logic [P_WIDTH-1:0] w_inv_res;

  logic w_degen;
  logic w_mul_req;
  logic w_inv_start;
  logic w_issue_reset;
  logic w_mul_reset;
  logic w_mul_enable;
  logic w_mul_done;
  logic w_op_done;
  logic w_inv_reset;
  logic w_inv_done;

  assign w_degen     = r_pinf | (r_py == '0);
  assign w_mul_reset = Reset | w_issue_reset;
  assign w_inv_reset = Reset | w_inv_start;

  add u_px2   (.i_a(P.x),       .i_b(P.x),     .i_sub(1'b0), .o_y(w_px2));
  add u_py2   (.i_a(P.y),       .i_b(P.y),     .i_sub(1'b0), .o_y(w_py2));
  add u_px3   (.i_a(r_px2),     .i_b(r_px),    .i_sub(1'b0), .o_y(w_px3));
  add u_t0    (.i_a(w_mul_res), .i_b(CURVE_A), .i_sub(1'b0), .o_y(w_t0));
  add u_rx    (.i_a(w_mul_res), .i_b(r_px2),   .i_sub(1'b1), .o_y(w_rx));
  add u_px_rx (.i_a(r_px),      .i_b(r_rx),    .i_sub(1'b1), .o_y(w_px_rx));
  add u_ry    (.i_a(w_mul_res), .i_b(r_py),    .i_sub(1'b1), .o_y(w_ry));

  mul_issue u_issue (
    .clk         (clk),
    .i_rst       (Reset),
    .i_req       (w_mul_req),
    .i_mul_done  (w_mul_done),
    .o_mul_reset (w_issue_reset),
    .o_mul_enable(w_mul_enable),
    .o_op_done   (w_op_done)
  );

  ModMul u_mul (
    .clk     (clk),
    .i_reset (w_mul_reset),
    .i_enable(w_mul_enable),
    .i_a     (w_mul_a),
    .i_b     (w_mul_b),
    .o_result(w_mul_res),
    .o_done  (w_mul_done)
  );

  modular_inverse u_inv (
    .clk     (clk),
    .i_reset (w_inv_reset),
    .i_x     ({{P_WIDTH{1'b0}}, r_py2}),
    .o_result(w_inv_res),
    .o_done  (w_inv_done)
  );

  always_ff @(posedge clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_sel       = SEL_NONE;
    w_mul_req   = 1'b0;
    w_inv_start = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = CHECK;
      CHECK: begin
        if (w_degen) begin
          w_next = DONE;
        end else begin
          w_inv_start = 1'b1;
          w_next      = MUL0;
        end
      end
      // A slow multiplier can finish after the inverse; skip WINV in that case.
      MUL0: begin
        w_mul_req = 1'b1;
        w_sel     = SEL_T0;
        if (w_op_done) w_next = w_inv_done ? MUL1 : WINV;
      end
      WINV:  if (w_inv_done) w_next = MUL1;
      MUL1: begin
        w_mul_req = 1'b1;
        w_sel     = SEL_S;
        if (w_op_done) w_next = MUL2;
      end
      MUL2: begin
        w_mul_req = 1'b1;
        w_sel     = SEL_Q;
        if (w_op_done) w_next = MUL3;
      end
      MUL3: begin
        w_mul_req = 1'b1;
        w_sel     = SEL_M;
        if (w_op_done) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (w_sel)
      SEL_T0:  begin w_mul_a = r_px; w_mul_b = w_px3;   end
      SEL_S:   begin w_mul_a = r_t0; w_mul_b = r_inv;   end
      SEL_Q:   begin w_mul_a = r_s;  w_mul_b = r_s;     end
      SEL_M:   begin w_mul_a = r_s;  w_mul_b = w_px_rx; end
      default: begin w_mul_a = '0;   w_mul_b = '0;      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_px    <= '0;
      r_py    <= '0;
      r_px2   <= '0;
      r_py2   <= '0;
      r_t0    <= '0;
      r_inv   <= '0;
      r_s     <= '0;
      r_rx    <= '0;
      r_pinf  <= 1'b0;
      r_r     <= '0;
      r_r_inf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_px   <= P.x;
            r_py   <= P.y;
            r_pinf <= P_inf;
            r_px2  <= w_px2;
            r_py2  <= w_py2;
          end
        end
        CHECK: begin
          if (w_degen) begin
            r_r     <= '0;
            r_r_inf <= 1'b1;
          end
        end
        MUL0: begin
          if (w_op_done) begin
            r_t0 <= w_t0;
            if (w_inv_done) r_inv <= w_inv_res;
          end
        end
        WINV: if (w_inv_done) r_inv <= w_inv_res;
        MUL1: if (w_op_done) r_s <= w_mul_res;
        MUL2: if (w_op_done) r_rx <= w_rx;
        MUL3: begin
          if (w_op_done) begin
            r_r.x   <= r_rx;
            r_r.y   <= w_ry;
            r_r_inf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != IDLE);
  assign Done  = (r_state == DONE);
  assign R     = r_r;
  assign R_inf = r_r_inf;

endmodule

// File: tb/tb_point_double_ctrl.sv
// Randomized bench for point_double_ctrl against a plain-arithmetic affine doubling model.
module tb_point_double_ctrl;
  import elliptic_curve_structs::*;

  localparam longint      PM     = 65521;
  localparam logic [15:0] A_COEF = 16'd5;
  localparam int          LM     = 17;   // multiplier: reset cycle to done
  localparam int          LI     = 33;   // inverse: reset cycle to done
  localparam int          LAT_NORM = 2 + ((LM + 1 > LI) ? (LM + 1) : LI) + 3 * (LM + 1) + 1;
  localparam int          LAT_DEG  = 3;
  // G lies on y^2 = x^3 + 5x + b for the b this pair implies; doubling never uses b.
  localparam longint      GX = 64'd4660;
  localparam longint      GY = 64'd9029;

  logic         clk = 1'b0;
  logic         Reset;
  logic         start;
  curve_point_t P;
  logic         P_inf;
  logic         busy;
  logic         Done;
  curve_point_t R;
  logic         R_inf;

  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  int   long_cnt = 0;
  int   en_cnt   = 0;
  logic done_q   = 1'b0;

  point_double_ctrl #(.CURVE_A(A_COEF)) dut (
    .clk  (clk),
    .Reset(Reset),
    .start(start),
    .P    (P),
    .P_inf(P_inf),
    .busy (busy),
    .Done (Done),
    .R    (R),
    .R_inf(R_inf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Done && !done_q) done_cnt++;
    if (Done && done_q)  long_cnt++;
    done_q = Done;
    if (dut.w_mul_enable) en_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint mpow(input longint b, input longint e);
    longint r = 1;
    longint bb = b % PM;
    longint ee = e;
    while (ee > 0) begin
      if (ee % 2 == 1) r = (r * bb) % PM;
      bb = (bb * bb) % PM;
      ee = ee / 2;
    end
    return r;
  endfunction

  task automatic model(input longint x, input longint y, input logic inf,
                       output longint rx, output longint ry, output logic rinf);
    longint num, lam;
    if (inf || y == 0) begin
      rx = 0; ry = 0; rinf = 1'b1;
    end else begin
      num  = ((3 * x % PM) * x + longint'(A_COEF)) % PM;
      lam  = (num * mpow((2 * y) % PM, PM - 2)) % PM;
      rx   = ((lam * lam) % PM - (2 * x) % PM + PM) % PM;
      ry   = ((lam * ((x - rx + PM) % PM)) % PM - y + PM) % PM;
      rinf = 1'b0;
    end
  endtask

  // Called at #1 after a clock edge with the DUT in IDLE; start is sampled on the next edge.
  task automatic do_op(input longint x, input longint y, input logic inf,
                       input int poke_at, input int rst_at, input string tag);
    longint ex, ey;
    logic   einf;
    int     n, d0, e0, exp_n;
    model(x, y, inf, ex, ey, einf);
    exp_n = (einf ? LAT_DEG : LAT_NORM) - 2;
    d0 = done_cnt;
    e0 = en_cnt;
    start = 1'b1; P.x = 16'(x); P.y = 16'(y); P_inf = inf;
    @(posedge clk); #1;
    start = 1'b0;
    P.x = 16'($urandom_range(0, PM - 1)); P.y = 16'($urandom_range(0, PM - 1)); P_inf = 1'($urandom);
    chk({tag, ".busy"}, longint'(busy), 1);
    n = 0;
    while (!Done && n < 400) begin
      if (n == poke_at) begin
        start = 1'b1; P.x = 16'($urandom_range(1, PM - 1)); P.y = 16'($urandom_range(1, PM - 1)); P_inf = 1'b0;
      end
      if (n == rst_at) Reset = 1'b1;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (Reset) begin
        Reset = 1'b0;
        chk({tag, ".rst_busy"}, longint'(busy), 0);
        chk({tag, ".rst_done"}, longint'(Done), 0);
        chk({tag, ".rst_r"}, longint'(R), 0);
        chk({tag, ".rst_rinf"}, longint'(R_inf), 0);
        return;
      end
    end
    chk({tag, ".latency"}, n, exp_n);
    chk({tag, ".rx"}, longint'(R.x), ex);
    chk({tag, ".ry"}, longint'(R.y), ey);
    chk({tag, ".rinf"}, longint'(R_inf), longint'(einf));
    if (einf) chk({tag, ".mul_en"}, en_cnt - e0, 0);
    @(posedge clk); #1;
    chk({tag, ".done_pulses"}, done_cnt - d0, 1);
    chk({tag, ".idle"}, longint'(busy), 0);
  endtask

  initial begin
    int rec;
    longint x, y;
    logic inf;
    Reset = 1'b1; start = 1'b0; P = '0; P_inf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", longint'(busy), 0);
    chk("reset.done", longint'(Done), 0);
    chk("reset.r", longint'(R), 0);
    chk("reset.rinf", longint'(R_inf), 0);
    Reset = 1'b0;
    @(posedge clk); #1;

    do_op(GX, GY, 1'b0, -1, -1, "gen");
    do_op(64'd1234, 0, 1'b0, -1, -1, "py0");
    do_op(longint'($urandom_range(0, PM - 1)), longint'($urandom_range(0, PM - 1)), 1'b1, -1, -1, "pinf");

    do_op(GX, GY, 1'b0, 40, -1, "ignore");
    rec = done_cnt;
    repeat (LAT_NORM + 10) @(posedge clk);
    #1;
    chk("ignore.no_queued_done", done_cnt - rec, 0);

    do_op(GX, GY, 1'b0, -1, 60, "abort");
    do_op(GX, GY, 1'b0, -1, -1, "after_abort");

    for (int i = 0; i < 100; i++) begin
      x   = longint'($urandom_range(0, PM - 1));
      y   = longint'($urandom_range(1, PM - 1));
      inf = 1'b0;
      case ($urandom_range(0, 15))
        0:       y = 0;
        1:       inf = 1'b1;
        default: ;
      endcase
      do_op(x, y, inf, -1, -1, "rnd");
    end

    chk("done_width", long_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
